alu_frame_tx: RTL and testbench

- Output stage directly downstream of the ALU framer.
- Captures 32-bit frame words presented on frame/frame_data into a word FIFO.
- Serializes them to a byte stream with a valid/ready handshake: header byte, 4 data bytes per word (MSB first), then an XOR checksum trailer per frame.
- Also provides a sticky overflow flag and a completed-frame counter.

---
 rtl/alu_frame_tx_if.sv | 25 ++
 rtl/alu_frame_tx.sv | 173 +++++++++++++++++
 tb/tb_alu_frame_tx.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_frame_tx_if.sv
// Byte-stream handshake between alu_frame_tx and its consumer.
// Master drives the byte and its framing marks; slave returns ready.
interface alu_frame_tx_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_sof;
  logic       tx_eof;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_sof,
    output tx_eof,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_sof,
    input  tx_eof,
    output tx_ready
  );
endinterface

// File: rtl/alu_frame_tx.sv
// ALU framer output stage: word FIFO plus byte serializer that adds
// a header byte and an XOR checksum trailer to each frame.
module alu_frame_tx #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame,
  input  logic [31:0]   frame_data,
  alu_frame_tx_if.master tx,
  output logic          fifo_full,
  output logic          ovfl,
  output logic [15:0]   frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] T_DAT = 2'b00;
  localparam logic [1:0] T_SOF = 2'b01;
  localparam logic [1:0] T_EOF = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CSUM
  } state_e;

  logic [33:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic [AW:0] count;
  logic        empty;
  logic        full;

  logic        frame_q;
  state_e      state_q;
  logic [1:0]  idx_q;
  logic [31:0] cur_q;
  logic [7:0]  csum_q;
  logic        vld_q;
  logic [7:0]  data_q;
  logic        sof_q;
  logic        eof_q;
  logic        ovfl_q;
  logic [15:0] cnt_q;

  logic        push_req;
  logic        push;
  logic        pop;
  logic        accept;
  logic [33:0] push_word;
  logic [33:0] head;
  logic [31:0] shifted;
  logic [7:0]  byte_d;

  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (count == DEPTH_C);
  assign head  = mem_q[rd_q[AW-1:0]];

  // A falling frame edge still writes, as a data-less EOF marker
  assign push_req  = frame | frame_q;
  assign push_word = frame ? {(frame_q ? T_DAT : T_SOF), frame_data}
                           : {T_EOF, 32'h0};

  assign pop    = (state_q == IDLE) && !empty;
  assign push   = push_req && (!full || pop);
  assign accept = vld_q && tx.tx_ready;

  assign shifted = cur_q << {idx_q + 2'd1, 3'b000};
  assign byte_d  = shifted[31:24];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cur_q   <= 32'h0;
      csum_q  <= 8'h00;
      vld_q   <= 1'b0;
      data_q  <= 8'h00;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ovfl_q  <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      frame_q <= frame;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push_req && full && !pop) ovfl_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (pop) begin
            cur_q <= head[31:0];
            case (head[33:32])
              T_SOF: begin
                state_q <= HDR;
                csum_q  <= 8'h00;
                vld_q   <= 1'b1;
                data_q  <= HDR_BYTE;
                sof_q   <= 1'b1;
              end
              T_DAT: begin
                state_q <= DATA;
                idx_q   <= 2'd0;
                vld_q   <= 1'b1;
                data_q  <= head[31:24];
              end
              T_EOF: begin
                state_q <= CSUM;
                vld_q   <= 1'b1;
                data_q  <= csum_q;
                eof_q   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        HDR: begin
          if (accept) begin
            state_q <= DATA;
            idx_q   <= 2'd0;
            data_q  <= cur_q[31:24];
            sof_q   <= 1'b0;
          end
        end
        DATA: begin
          if (accept) begin
            csum_q <= csum_q ^ data_q;
            if (idx_q == 2'd3) begin
              state_q <= IDLE;
              vld_q   <= 1'b0;
            end else begin
              idx_q  <= idx_q + 2'd1;
              data_q <= byte_d;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            csum_q  <= 8'h00;
            cnt_q   <= cnt_q + 16'd1;
            state_q <= IDLE;
            vld_q   <= 1'b0;
            eof_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_valid = vld_q;
  assign tx.tx_data  = data_q;
  assign tx.tx_sof   = sof_q;
  assign tx.tx_eof   = eof_q;
  assign fifo_full   = full;
  assign ovfl        = ovfl_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_frame_tx.sv
// Bench for alu_frame_tx: random frames and ready patterns checked
// against a frame-level byte-stream model.
module tb_alu_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic [31:0] frame_data = 32'h0;
  logic        fifo_full;
  logic        ovfl;
  logic [15:0] frame_cnt;

  alu_frame_tx_if txif();

  alu_frame_tx #(
    .FIFO_DEPTH(8),
    .HDR_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame(frame),
    .frame_data(frame_data),
    .tx(txif.master),
    .fifo_full(fifo_full),
    .ovfl(ovfl),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // byte records are {sof, eof, data}
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [9:0] cur_b;
  logic [9:0] prev_b = 10'h0;
  logic       prev_stall = 1'b0;
  int         stall_viol = 0;

  int   rmode = 0;
  logic rforce = 1'b1;
  int   bp_cnt = 0;

  assign cur_b = {txif.tx_sof, txif.tx_eof, txif.tx_data};

  initial begin
    txif.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rmode == 2) bp_cnt++;
      else bp_cnt = 0;
      case (rmode)
        1: txif.tx_ready = ($urandom_range(0, 99) < 70);
        2: txif.tx_ready = (bp_cnt >= 6 && bp_cnt < 13) ? 1'b0 : bp_cnt[0];
        default: txif.tx_ready = rforce;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!txif.tx_valid || cur_b != prev_b))
        stall_viol <= stall_viol + 1;
      if (txif.tx_valid && txif.tx_ready)
        got_q.push_back(cur_b);
      prev_stall <= txif.tx_valid && !txif.tx_ready;
      prev_b     <= cur_b;
    end
  end

  function automatic void model_frame(input logic [31:0] w[$]);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.push_back({2'b10, 8'hA5});
    foreach (w[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(w[i] >> (24 - 8 * k));
        cs = cs ^ b;
        exp_q.push_back({2'b00, b});
      end
    end
    exp_q.push_back({2'b01, cs});
  endfunction

  task automatic drive_frame(input logic [31:0] w[$]);
    foreach (w[i]) begin
      frame = 1'b1;
      frame_data = w[i];
      @(posedge clk);
      #1;
    end
    frame = 1'b0;
    frame_data = $urandom;
  endtask

  task automatic wait_drain(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (got_q.size() >= exp_q.size() && !txif.tx_valid) begin
        to = 1'b0;
        break;
      end
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (txif.tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", txif.tx_valid);
    end
    checks++;
    if (txif.tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h want 00", txif.tx_data);
    end
    checks++;
    if (txif.tx_sof !== 1'b0 || txif.tx_eof !== 1'b0) begin
      errors++; $display("FAIL reset_marks: got %b%b want 00", txif.tx_sof, txif.tx_eof);
    end
    checks++;
    if (ovfl !== 1'b0 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovfl=%b full=%b want 0 0", ovfl, fifo_full);
    end
    checks++;
    if (frame_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] w[$];
    bit to;
    int bad;
    rmode = 0; rforce = 1'b1;
    clear_q();
    repeat (2) @(posedge clk);
    #1;
    w = '{32'h11223344};
    model_frame(w);
    frame = 1'b1;
    frame_data = 32'h11223344;
    @(posedge clk);
    #1;
    frame = 1'b0;
    checks++;
    if (txif.tx_valid !== 1'b0) begin
      errors++; $display("FAIL single_lat_n1: got valid %b want 0", txif.tx_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (txif.tx_valid !== 1'b1 || cur_b !== {2'b10, 8'hA5}) begin
      errors++; $display("FAIL single_lat_n2: got valid %b byte %h want 1 2a5", txif.tx_valid, cur_b);
    end
    wait_drain(to);
    checks++;
    if (to) begin
      errors++; $display("FAIL single_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL single_bytes: got %0d wrong want 0", bad);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++; $display("FAIL single_cnt: got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_two_word();
    logic [31:0] w[$];
    logic [15:0] fc0;
    bit to;
    int bad;
    clear_q();
    fc0 = frame_cnt;
    w = '{32'hDEADBEEF, 32'h01020304};
    model_frame(w);
    drive_frame(w);
    wait_drain(to);
    checks++;
    if (to) begin
      errors++; $display("FAIL two_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL two_bytes: got %0d wrong of %0d want 0 of %0d", bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== {2'b01, 8'h26}) begin
      errors++; $display("FAIL two_csum: got %h want 126", (got_q.size() == 0) ? 10'h0 : got_q[got_q.size()-1]);
    end
    checks++;
    if (frame_cnt !== fc0 + 16'd1) begin
      errors++; $display("FAIL two_cnt: got %0d want %0d", frame_cnt, fc0 + 16'd1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[$];
    bit to;
    int bad;
    clear_q();
    w = '{$urandom, $urandom};
    model_frame(w);
    rmode = 2;
    drive_frame(w);
    repeat (30) @(posedge clk);
    #1;
    rmode = 0; rforce = 1'b1;
    wait_drain(to);
    checks++;
    if (to) begin
      errors++; $display("FAIL bp_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_bytes: got %0d wrong of %0d want 0 of %0d", bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w[$];
    logic [15:0] fc0;
    logic [7:0]  b;
    bit to;
    int bad;
    clear_q();
    fc0 = frame_cnt;
    rmode = 0; rforce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) w.push_back($urandom);
    // one word waits in the serializer, eight fit the FIFO, the rest drop
    exp_q.push_back({2'b10, 8'hA5});
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < 4; k++) begin
        b = 8'(w[i] >> (24 - 8 * k));
        exp_q.push_back({2'b00, b});
      end
    drive_frame(w);
    @(posedge clk);
    #1;
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++; $display("FAIL ovf_full: got %b want 1", fifo_full);
    end
    checks++;
    if (ovfl !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got %b want 1", ovfl);
    end
    rforce = 1'b1;
    wait_drain(to);
    checks++;
    if (to) begin
      errors++; $display("FAIL ovf_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_bytes: got %0d wrong of %0d want 0 of %0d", bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (ovfl !== 1'b1 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL ovf_after: got ovfl=%b full=%b want 1 0", ovfl, fifo_full);
    end
    checks++;
    if (frame_cnt !== fc0) begin
      errors++; $display("FAIL ovf_cnt: got %0d want %0d", frame_cnt, fc0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1[$];
    logic [31:0] w2[$];
    logic [15:0] fc0;
    bit to;
    int bad;
    clear_q();
    fc0 = frame_cnt;
    rmode = 1;
    w1 = '{$urandom, $urandom};
    w2 = '{$urandom};
    model_frame(w1);
    model_frame(w2);
    drive_frame(w1);
    @(posedge clk);
    #1;
    drive_frame(w2);
    wait_drain(to);
    rmode = 0; rforce = 1'b1;
    checks++;
    if (to) begin
      errors++; $display("FAIL b2b_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_bytes: got %0d wrong of %0d want 0 of %0d", bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (frame_cnt !== fc0 + 16'd2) begin
      errors++; $display("FAIL b2b_cnt: got %0d want %0d", frame_cnt, fc0 + 16'd2);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] w[$];
    bit to;
    bit seen;
    int bad;
    clear_q();
    rmode = 0; rforce = 1'b1;
    w = '{$urandom, $urandom};
    drive_frame(w);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (got_q.size() >= 2) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_mid_reach: got %0d bytes want 2", got_q.size());
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (txif.tx_valid !== 1'b0 || frame_cnt !== 16'h0 || ovfl !== 1'b0 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got valid=%b cnt=%0d ovfl=%b full=%b want 0 0 0 0",
                         txif.tx_valid, frame_cnt, ovfl, fifo_full);
    end
    clear_q();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0 || txif.tx_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_empty: got %0d bytes valid=%b want 0 0", got_q.size(), txif.tx_valid);
    end
    w = '{$urandom};
    model_frame(w);
    drive_frame(w);
    wait_drain(to);
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (to || bad != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_mid_new: got %0d wrong of %0d want 0 of %0d", bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++; $display("FAIL rst_mid_cnt: got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    logic [15:0] fc0;
    bit to;
    int tos;
    int bad;
    clear_q();
    fc0 = frame_cnt;
    tos = 0;
    rmode = 1;
    for (int f = 0; f < 15; f++) begin
      w.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) w.push_back($urandom);
      model_frame(w);
      drive_frame(w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      wait_drain(to);
      if (to) tos++;
    end
    rmode = 0; rforce = 1'b1;
    checks++;
    if (tos != 0) begin
      errors++; $display("FAIL rand_timeout: got %0d timeouts want 0", tos);
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_bytes: got %0d wrong of %0d want 0 of %0d", bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (frame_cnt !== fc0 + 16'd15) begin
      errors++; $display("FAIL rand_cnt: got %0d want %0d", frame_cnt, fc0 + 16'd15);
    end
    checks++;
    if (ovfl !== 1'b0 || stall_viol != 0) begin
      errors++; $display("FAIL rand_flags: got ovfl=%b stalls=%0d want 0 0", ovfl, stall_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_word();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
